// File: rtl/welford_div_scheduler_if.sv
// rtl/welford_div_scheduler_if.sv - request/response bundle between Welford lanes and the shared divider
interface welford_div_scheduler_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 20,
  parameter int SHIFT_WIDTH = $clog2(COUNT_WIDTH),
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_num;
  logic [NUM_REQ*COUNT_WIDTH-1:0] req_count;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [ID_WIDTH-1:0]            resp_id;
  logic [DATA_WIDTH-1:0]          resp_quot;
  logic [SHIFT_WIDTH-1:0]         resp_shift;
  logic                           busy;

  modport master (
    output req_valid, req_num, req_count, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_quot, resp_shift, busy
  );

  modport slave (
    input  req_valid, req_num, req_count, resp_ready,
    output req_ready, resp_valid, resp_id, resp_quot, resp_shift, busy
  );
endinterface

// File: rtl/welford_div_scheduler.sv
// rtl/welford_div_scheduler.sv - round-robin shared power-of-two approximate divider for Welford lanes
module welford_div_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 20,
  parameter int SHIFT_WIDTH = $clog2(COUNT_WIDTH),
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                    clk_lookup,
  input  logic                    clk_lookup_rst_high,
  welford_div_scheduler_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [NUM_REQ-1:0] LANE0 = 1;
  localparam logic [COUNT_WIDTH:0] ONE = 1;

  logic [1:0]                    state_q, state_d;
  logic [ID_WIDTH-1:0]           rr_ptr_q, rr_ptr_d;
  logic signed [DATA_WIDTH-1:0]  num_q, num_d;
  logic [COUNT_WIDTH-1:0]        count_q, count_d;
  logic [ID_WIDTH-1:0]           id_q, id_d;
  logic                          resp_valid_q, resp_valid_d;
  logic [ID_WIDTH-1:0]           resp_id_q, resp_id_d;
  logic [DATA_WIDTH-1:0]         resp_quot_q, resp_quot_d;
  logic [SHIFT_WIDTH-1:0]        resp_shift_q, resp_shift_d;

  logic                          grant_found;
  logic [ID_WIDTH-1:0]           grant_id, cand;
  logic [SHIFT_WIDTH-1:0]        msb, shift_calc;
  logic [COUNT_WIDTH:0]          cnt_ext, pow_lo, pow_hi, diff_up, diff_dn;
  logic [DATA_WIDTH-1:0]         quot_calc;

  // Scan starts at rr_ptr so the lane after the last one served has priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE && grant_found && !clk_lookup_rst_high)
                         ? (LANE0 << grant_id) : '0;

  // Nearest power of two: compare distance to 2^k and 2^(k+1), ties go to k.
  always_comb begin
    msb = '0;
    for (int b = 0; b < COUNT_WIDTH; b++) begin
      if (count_q[b]) msb = SHIFT_WIDTH'(b);
    end
    cnt_ext = {1'b0, count_q};
    pow_lo  = ONE << msb;
    pow_hi  = pow_lo << 1;
    diff_up = pow_hi - cnt_ext;
    diff_dn = cnt_ext - pow_lo;
    if (count_q <= COUNT_WIDTH'(1)) shift_calc = '0;
    else if (diff_up < diff_dn)     shift_calc = msb + SHIFT_WIDTH'(1);
    else                            shift_calc = msb;
    quot_calc = num_q >>> shift_calc;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    num_d        = num_q;
    count_d      = count_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_quot_d  = resp_quot_q;
    resp_shift_d = resp_shift_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          num_d   = bus.req_num[grant_id*DATA_WIDTH +: DATA_WIDTH];
          count_d = bus.req_count[grant_id*COUNT_WIDTH +: COUNT_WIDTH];
          id_d    = grant_id;
          state_d = CALC;
        end
      end
      CALC: begin
        resp_quot_d  = quot_calc;
        resp_shift_d = shift_calc;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          rr_ptr_d     = (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + ID_WIDTH'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_lookup) begin
    if (clk_lookup_rst_high) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      num_q        <= '0;
      count_q      <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_quot_q  <= '0;
      resp_shift_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      num_q        <= num_d;
      count_q      <= count_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_quot_q  <= resp_quot_d;
      resp_shift_q <= resp_shift_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_quot  = resp_quot_q;
  assign bus.resp_shift = resp_shift_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
